// File: rtl/fir_2ch_scheduler.sv
// rtl/fir_2ch_scheduler.sv - stereo sample scheduler for a shared 2-channel FIR (left=SOP, right=EOP)
// Optional overrun statistics are enabled by defining FIR_OVERRUN_STAT_EN.
module fir_2ch_scheduler #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        AMCLK_i,
    input  logic        nARST,
    input  logic [15:0] APDATA_LEFT_i,
    input  logic [15:0] APDATA_RIGHT_i,
    input  logic        APDATA_VALID_i,
    output logic [15:0] SINK_DATA_o,
    output logic        SINK_VALID_o,
    output logic        SINK_SOP_o,
    output logic        SINK_EOP_o,
    input  logic        SINK_READY_i,
    input  logic [23:0] SOURCE_DATA_i,
    input  logic        SOURCE_VALID_i,
    input  logic        SOURCE_SOP_i,
    input  logic        SOURCE_EOP_i,
    output logic [23:0] APDATA_INT_LEFT_o,
    output logic [23:0] APDATA_INT_RIGHT_o,
    output logic        APDATA_INT_VALID_o,
    output logic        BUSY_o
`ifdef FIR_OVERRUN_STAT_EN
    ,
    output logic        OVERRUN_o,
    output logic [7:0]  DROP_CNT_o
`endif
);

    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam bit         NO_GAP   = (GAP_CYCLES == 0);

    state_t      state_q;
    logic [3:0]  gap_cnt_q;
    logic [15:0] act_r_q;
    logic        pend_full_q;
    logic [15:0] pend_l_q;
    logic [15:0] pend_r_q;
    logic [15:0] sink_data_q;
    logic        sink_valid_q;
    logic        sink_sop_q;
    logic        sink_eop_q;
    logic [23:0] int_left_q;
    logic [23:0] int_right_q;
    logic        int_valid_q;

    logic sink_fire;
    logic load_pend;
    logic load_new;
    logic cap_pend;
    logic drop;
    logic [15:0] next_left;
    logic [15:0] next_right;

    assign sink_fire = sink_valid_q & SINK_READY_i;

    // load_pend: the pending frame moves into the active slot this cycle
    always_comb begin
        load_pend = 1'b0;
        case (state_q)
            IDLE:    load_pend = pend_full_q;
            SEND_R:  load_pend = NO_GAP && sink_fire && pend_full_q;
            GAP:     load_pend = (gap_cnt_q == GAP_LAST) && pend_full_q;
            default: load_pend = 1'b0;
        endcase
    end

    assign load_new   = (state_q == IDLE) && !pend_full_q && APDATA_VALID_i;
    assign cap_pend   = APDATA_VALID_i && !load_new && (!pend_full_q || load_pend);
    assign drop       = APDATA_VALID_i && pend_full_q && !load_pend;
    assign next_left  = load_pend ? pend_l_q : APDATA_LEFT_i;
    assign next_right = load_pend ? pend_r_q : APDATA_RIGHT_i;

    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            state_q      <= IDLE;
            gap_cnt_q    <= 4'd0;
            act_r_q      <= 16'd0;
            pend_full_q  <= 1'b0;
            pend_l_q     <= 16'd0;
            pend_r_q     <= 16'd0;
            sink_data_q  <= 16'd0;
            sink_valid_q <= 1'b0;
            sink_sop_q   <= 1'b0;
            sink_eop_q   <= 1'b0;
        end else begin
            if (cap_pend) begin
                pend_l_q    <= APDATA_LEFT_i;
                pend_r_q    <= APDATA_RIGHT_i;
                pend_full_q <= 1'b1;
            end else if (load_pend) begin
                pend_full_q <= 1'b0;
            end

            if (load_pend || load_new) begin
                state_q      <= SEND_L;
                act_r_q      <= next_right;
                sink_data_q  <= next_left;
                sink_valid_q <= 1'b1;
                sink_sop_q   <= 1'b1;
                sink_eop_q   <= 1'b0;
            end else begin
                case (state_q)
                    SEND_L: begin
                        if (sink_fire) begin
                            state_q     <= SEND_R;
                            sink_data_q <= act_r_q;
                            sink_sop_q  <= 1'b0;
                            sink_eop_q  <= 1'b1;
                        end
                    end
                    SEND_R: begin
                        if (sink_fire) begin
                            state_q      <= NO_GAP ? IDLE : GAP;
                            gap_cnt_q    <= 4'd0;
                            sink_valid_q <= 1'b0;
                            sink_eop_q   <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Source beats with SOP==EOP are malformed and leave the outputs untouched
    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            int_left_q  <= 24'd0;
            int_right_q <= 24'd0;
            int_valid_q <= 1'b0;
        end else begin
            int_valid_q <= 1'b0;
            if (SOURCE_VALID_i && SOURCE_SOP_i && !SOURCE_EOP_i) begin
                int_left_q <= SOURCE_DATA_i;
            end
            if (SOURCE_VALID_i && SOURCE_EOP_i && !SOURCE_SOP_i) begin
                int_right_q <= SOURCE_DATA_i;
                int_valid_q <= 1'b1;
            end
        end
    end

`ifdef FIR_OVERRUN_STAT_EN
    logic       overrun_q;
    logic [7:0] drop_cnt_q;

    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign OVERRUN_o  = overrun_q;
    assign DROP_CNT_o = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign SINK_DATA_o        = sink_data_q;
    assign SINK_VALID_o       = sink_valid_q;
    assign SINK_SOP_o         = sink_sop_q;
    assign SINK_EOP_o         = sink_eop_q;
    assign APDATA_INT_LEFT_o  = int_left_q;
    assign APDATA_INT_RIGHT_o = int_right_q;
    assign APDATA_INT_VALID_o = int_valid_q;
    assign BUSY_o             = (state_q != IDLE) || pend_full_q;

endmodule
